// File: rtl/adder_pkg.sv
// Shared types for the serial nibble adder.
// FSM state encoding and digit width.
package adder_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit ripple-carry digit adder.
// One instance is reused every cycle by the serial adder.
module nibble_add
  import adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] c;

  // Ripple the carry bit by bit through the digit
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DIGIT_W];
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Digit-serial adder: one 4-bit digit per cycle, LSB first.
// Optional signed-overflow output V under SERIAL_ADDER_OVF_EN.
module serial_nibble_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIGIT_W*NIBBLES-1:0]   A,
  input  logic [DIGIT_W*NIBBLES-1:0]   B,
  input  logic                         Cin,
  output logic                         busy,
  output logic                         done,
  output logic [DIGIT_W*NIBBLES-1:0]   Sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic                         V,
`endif
  output logic                         Cout
);

  localparam int W  = DIGIT_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q, b_q, acc_q;
  logic [W-1:0]    a_d, b_d, acc_d;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_s;
  logic               dig_c;

  assign dig_a = a_q[DIGIT_W-1:0];
  assign dig_b = b_q[DIGIT_W-1:0];

  nibble_add u_nibble_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_s),
    .cout (dig_c)
  );

  // Consume the low digit of each operand; insert the new sum at the top
  always_comb begin
    a_d   = a_q >> DIGIT_W;
    b_d   = b_q >> DIGIT_W;
    acc_d = W'({dig_s, acc_q} >> DIGIT_W);
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic v_q;
  logic msb_cin;
  assign msb_cin = dig_a[DIGIT_W-1] ^ dig_b[DIGIT_W-1] ^ dig_s[DIGIT_W-1];
`endif

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          acc_q   <= acc_d;
          carry_q <= dig_c;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            sum_q   <= acc_d;
            cout_q  <= dig_c;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= msb_cin ^ dig_c;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign V    = v_q;
`endif

endmodule
